// File: rtl/tanh_pkg.sv
// Shared defaults, mode encoding and the elaboration-time tanh breakpoint table
// for the streaming tanh activation unit.
package tanh_pkg;

  localparam int unsigned TANH_W    = 8;
  localparam int unsigned TANH_FRAC = 5;
  localparam int unsigned TANH_NSEG = 8;

  typedef enum logic {
    TANH_PWL  = 1'b0,
    TANH_HARD = 1'b1
  } tanh_mode_e;

  // tanh(0.5) in Q2.30, seed for the addition-formula recurrence below
  localparam longint unsigned TANH_T0_Q30 = 64'd496194519;

  // E[i] = min(round(tanh(i*0.5) * 2^(w-1)), 2^(w-1)-1), built from
  // tanh(a+b) = (tanh a + tanh b) / (1 + tanh a * tanh b) in Q2.30.
  function automatic int unsigned tanh_tab(input int unsigned i, input int unsigned w);
    longint unsigned t;
    longint unsigned num;
    longint unsigned den;
    longint unsigned e;
    longint unsigned maxv;
    t = 64'd0;
    for (int unsigned j = 0; j < i; j++) begin
      num = (t + TANH_T0_Q30) << 30;
      den = (64'd1 << 30) + ((t * TANH_T0_Q30) >> 30);
      t   = num / den;
    end
    e    = ((t << (w - 1)) + (64'd1 << 29)) >> 30;
    maxv = (64'd1 << (w - 1)) - 64'd1;
    if (e > maxv) e = maxv;
    return 32'(e);
  endfunction

endpackage

// File: rtl/tanh_pwl_seg.sv
// Combinational stage-2 datapath: PWL interpolation, hard-tanh clamp and sign
// application on the registered stage-1 operands.
module tanh_pwl_seg
  import tanh_pkg::*;
#(
  parameter int unsigned W    = TANH_W,
  parameter int unsigned FRAC = TANH_FRAC
) (
  input  logic            mode,
  input  logic            sign,
  input  logic [W-1:0]    m,
  input  logic [FRAC-2:0] r,
  input  logic            sat1,
  input  logic [W-1:0]    e0,
  input  logic [W-1:0]    e1,
  output logic [W-1:0]    y_c
);

  localparam int unsigned RW = FRAC - 1;
  localparam int unsigned SH = W - 1 - FRAC;
  localparam int unsigned PW = W + RW;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE  = W'(1) << FRAC;

  logic [W-1:0]  diff;
  logic [PW-1:0] prod;
  logic [W-1:0]  interp;
  logic [W-1:0]  hard;
  logic [W-1:0]  mag;

  // Table is monotonic, so the slope is never negative and floor is a plain shift
  always_comb begin
    diff   = e1 - e0;
    prod   = PW'(diff) * PW'(r);
    interp = e0 + W'(prod >> RW);
    hard   = (m >= ONE) ? MAXV : W'(m << SH);
    mag    = sat1 ? MAXV : interp;
    if (tanh_mode_e'(mode) == TANH_HARD) mag = hard;
    y_c    = sign ? W'(~mag + W'(1)) : mag;
  end

endmodule

// File: rtl/tanh_pwl_stream.sv
// Streaming tanh activation: 2-stage valid/ready pipeline, PWL or hard-tanh per beat.
// Optional saturation counter enabled by defining TANH_SAT_CNT_EN.
module tanh_pwl_stream
  import tanh_pkg::*;
#(
  parameter int unsigned W    = TANH_W,
  parameter int unsigned FRAC = TANH_FRAC,
  parameter int unsigned NSEG = TANH_NSEG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef TANH_SAT_CNT_EN
  ,
  output logic [15:0]  sat_count
`endif
);

  localparam int unsigned RW = FRAC - 1;
  localparam int unsigned IW = $clog2(NSEG + 1);

  logic [W-1:0] etab [0:NSEG];

  for (genvar i = 0; i <= int'(NSEG); i++) begin : g_tab
    assign etab[i] = W'(tanh_pkg::tanh_tab(32'(i), W));
  end

  logic          en;
  logic [W-1:0]  m_c;
  logic [W-1:0]  k_c;
  logic          sat1_c;
  logic [IW-1:0] k_idx_c;
  logic [IW-1:0] k1_idx_c;

  logic          s1_valid;
  logic          s1_sign;
  logic          s1_mode;
  logic [W-1:0]  s1_m;
  logic [RW-1:0] s1_r;
  logic          s1_sat;
  logic [W-1:0]  s1_e0;
  logic [W-1:0]  s1_e1;
  logic [W-1:0]  y_c;

  // Both stages move together; a held output freezes the whole pipe
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Unsigned W-bit magnitude: the most negative input maps to 2^(W-1) cleanly
  assign m_c      = in_data[W-1] ? W'(~in_data + W'(1)) : in_data;
  assign k_c      = m_c >> RW;
  assign sat1_c   = k_c >= W'(NSEG);
  assign k_idx_c  = sat1_c ? '0 : IW'(k_c);
  assign k1_idx_c = IW'(k_idx_c + IW'(1));

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s1_sign <= in_data[W-1];
      s1_mode <= in_mode;
      s1_m    <= m_c;
      s1_r    <= m_c[RW-1:0];
      s1_sat  <= sat1_c;
      s1_e0   <= etab[k_idx_c];
      s1_e1   <= etab[k1_idx_c];
    end
  end

  tanh_pwl_seg #(
    .W    (W),
    .FRAC (FRAC)
  ) u_seg (
    .mode (s1_mode),
    .sign (s1_sign),
    .m    (s1_m),
    .r    (s1_r),
    .sat1 (s1_sat),
    .e0   (s1_e0),
    .e1   (s1_e1),
    .y_c  (y_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) out_data <= y_c;
    end
  end

`ifdef TANH_SAT_CNT_EN
  localparam logic [W-1:0] ONE = W'(1) << FRAC;

  logic sat_c;
  logic out_sat;

  // Saturation definition depends on the mode the beat carried
  assign sat_c = (tanh_mode_e'(s1_mode) == TANH_HARD) ? (s1_m >= ONE) : s1_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (en && s1_valid) begin
      out_sat <= sat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tanh_pwl_stream.sv
// Self-checking bench for tanh_pwl_stream (default W=8, FRAC=5, NSEG=8),
// including the sat_count port when TANH_SAT_CNT_EN is defined.
module tb_tanh_pwl_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef TANH_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  tanh_pwl_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef TANH_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam int E [0:8] = '{0, 59, 97, 116, 123, 126, 127, 127, 127};

  // {sat, y}: tanh approximation straight from the arithmetic definition
  function automatic logic [8:0] ref_model(input logic [7:0] x, input logic hard);
    int xv, m, k, r, mag, y;
    bit sat;
    xv = int'($signed(x));
    m  = (xv < 0) ? -xv : xv;
    if (hard) begin
      sat = (m >= 32);
      mag = (m * 4 > 127) ? 127 : m * 4;
    end else begin
      k   = m / 16;
      r   = m % 16;
      sat = (k >= 8);
      mag = sat ? 127 : E[k] + ((E[k+1] - E[k]) * r) / 16;
    end
    y = (xv < 0) ? -mag : mag;
    return {sat, 8'(y)};
  endfunction

  logic [8:0] q[$];
  int         exp_sat;

  logic       t_acc, t_hs, t_ov, t_ir, t_under;
  logic [7:0] t_obs;
  logic [8:0] t_exp;

  // One cycle: drive at negedge, sample 1 time unit later, advance to next negedge
  task automatic tick(input logic v, input logic [7:0] d, input logic md, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = md;
    out_ready = ordy;
    #1;
    t_acc   = in_valid && in_ready;
    t_hs    = out_valid && out_ready;
    t_ov    = out_valid;
    t_ir    = in_ready;
    t_obs   = out_data;
    t_under = 1'b0;
    t_exp   = '0;
    if (t_hs) begin
      if (q.size() == 0) t_under = 1'b1;
      else begin
        t_exp = q.pop_front();
        if (t_exp[8] && exp_sat != 65535) exp_sat++;
      end
    end
    if (t_acc) q.push_back(ref_model(d, md));
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_sat = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
`ifdef TANH_SAT_CNT_EN
    checks++;
    if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count got=%0d want=0", sat_count); end
`endif
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] dx [0:10] = '{8'h00, 8'h20, 8'hE0, 8'h10, 8'h18, 8'h7F, 8'h80, 8'h10, 8'h30, 8'hD0, 8'h40};
    logic       dm [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] dy [0:10] = '{8'h00, 8'h61, 8'h9F, 8'h3B, 8'h4E, 8'h7F, 8'h81, 8'h40, 8'h7F, 8'h81, 8'h7B};
    int lat;
    for (int i = 0; i <= 10; i++) begin
      tick(1'b1, dx[i], dm[i], 1'b1);
      checks++;
      if (!t_acc) begin errors++; $display("FAIL dir_accept idx=%0d got=0 want=1", i); end
      lat = 0;
      for (int c = 0; c < 8; c++) begin
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        lat++;
        if (t_hs) break;
      end
      checks++;
      if (lat != 2 || !t_hs) begin errors++; $display("FAIL dir_latency idx=%0d got=%0d want=2", i, lat); end
      checks++;
      if (t_obs !== dy[i]) begin
        errors++;
        $display("FAIL dir_data x=%h mode=%0d got=%h want=%h", dx[i], dm[i], t_obs, dy[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bx [0:5] = '{8'h05, 8'hF0, 8'h22, 8'h80, 8'h3C, 8'hC8};
    int sent, got, cyc;
    logic [7:0] prev;
    logic prev_stall;
    sent = 0; got = 0; cyc = 0; prev = '0; prev_stall = 1'b0;
    while (got < 6 && cyc < 40) begin
      tick(sent < 6, (sent < 6) ? bx[sent] : 8'h00, 1'(sent % 2), !(cyc >= 3 && cyc < 6));
      if (t_acc) sent++;
      if (t_ov && !out_ready) begin
        checks++;
        if (t_ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, t_ir); end
        if (prev_stall) begin
          checks++;
          if (t_obs !== prev) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, t_obs, prev); end
        end
        prev = t_obs;
        prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      if (t_hs) begin
        got++;
        checks++;
        if (t_under || t_obs !== t_exp[7:0]) begin
          errors++; $display("FAIL bp_data n=%0d got=%h want=%h", got, t_obs, t_exp[7:0]);
        end
      end
      cyc++;
    end
    checks++;
    if (got != 6 || q.size() != 0) begin errors++; $display("FAIL bp_count got=%0d want=6", got); end
  endtask

  task automatic test_random();
    logic [7:0] x;
    logic [7:0] edges [0:5] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h20};
    int cyc;
    for (int i = 0; i < 400; i++) begin
      x = (i % 8 == 0) ? edges[$urandom_range(0, 5)] : 8'($urandom);
      tick($urandom_range(0, 9) < 7, x, 1'($urandom), $urandom_range(0, 9) < 7);
      if (t_hs) begin
        checks++;
        if (t_under || t_obs !== t_exp[7:0]) begin
          errors++; $display("FAIL rand_data cyc=%0d got=%h want=%h", i, t_obs, t_exp[7:0]);
        end
      end
    end
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      if (t_hs) begin
        checks++;
        if (t_under || t_obs !== t_exp[7:0]) begin
          errors++; $display("FAIL rand_drain got=%h want=%h", t_obs, t_exp[7:0]);
        end
      end
      cyc++;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_timeout left=%0d want=0", q.size()); end
`ifdef TANH_SAT_CNT_EN
    checks++;
    if (sat_count !== 16'(exp_sat)) begin errors++; $display("FAIL rand_sat_count got=%0d want=%0d", sat_count, exp_sat); end
`endif
  endtask

`ifdef TANH_SAT_CNT_EN
  task automatic test_sat_count();
    logic [7:0] sx [0:4] = '{8'h80, 8'h30, 8'h30, 8'h10, 8'h00};
    logic       sm [0:4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int sent, cyc;
    do_reset(1);
    sent = 0; cyc = 0;
    while ((sent < 5 || q.size() != 0) && cyc < 40) begin
      tick(sent < 5, (sent < 5) ? sx[sent] : 8'h00, (sent < 5) ? sm[sent] : 1'b0, !(cyc >= 2 && cyc < 5));
      if (t_acc) sent++;
      checks++;
      if (sat_count !== 16'(exp_sat)) begin
        errors++; $display("FAIL sat_track cyc=%0d got=%0d want=%0d", cyc, sat_count, exp_sat);
      end
      cyc++;
    end
    checks++;
    if (sat_count !== 16'd3) begin errors++; $display("FAIL sat_final got=%0d want=3", sat_count); end
  endtask
`endif

  task automatic test_reset_inflight();
    int cyc;
    tick(1'b1, 8'h80, 1'b0, 1'b0);
    tick(1'b1, 8'h20, 1'b1, 1'b0);
    do_reset(1);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flight_ready got=%b want=1", in_ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (t_hs) begin errors++; $display("FAIL rst_ghost cyc=%0d got=%h want=none", i, t_obs); end
    end
    tick(1'b1, 8'hE0, 1'b0, 1'b1);
    cyc = 0;
    t_hs = 1'b0;
    while (!t_hs && cyc < 10) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      cyc++;
    end
    checks++;
    if (!t_hs || t_obs !== 8'h9F) begin errors++; $display("FAIL rst_new_beat got=%h want=9f", t_obs); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    exp_sat = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
`ifdef TANH_SAT_CNT_EN
    test_sat_count();
`endif
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
